// File: rtl/multdiv_pkg.sv
// Shared opcode and state enums for the iterative multiply/divide unit.
// Also holds small opcode-class helpers used by the top.
package multdiv_pkg;

  typedef enum logic [3:0] {
    OP_MFHI  = 4'h0,
    OP_MTHI  = 4'h1,
    OP_MFLO  = 4'h2,
    OP_MTLO  = 4'h3,
    OP_MULT  = 4'h8,
    OP_MULTU = 4'h9,
    OP_DIV   = 4'hA,
    OP_DIVU  = 4'hB
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  // Multiply/divide occupy codes 10xx.
  function automatic logic is_md_op(input logic [3:0] f);
    return (f[3:2] == 2'b10);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] f);
    return (f == OP_MULT) || (f == OP_DIV);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-divide iteration: shift in a dividend bit, trial-subtract the divisor.
// Purely combinational; the remainder is carried one bit wider than the divisor.
module div_step
  import multdiv_pkg::*;
#(
  parameter int N = 18
) (
  input  logic [N:0]   rem_in,
  input  logic         bit_in,
  input  logic [N-1:0] divisor,
  output logic [N:0]   rem_out,
  output logic         qbit
);

  logic [N:0] shifted;
  logic [N:0] diff;

  assign shifted = {rem_in[N-1:0], bit_in};
  assign diff    = shifted - {1'b0, divisor};
  // rem_in[N] is zero for any legal partial remainder; folding it in keeps the step total.
  assign qbit    = rem_in[N] | (shifted >= {1'b0, divisor});
  assign rem_out = qbit ? diff : shifted;

endmodule

// File: rtl/iter_multdiv.sv
// Iterative HI/LO multiply/divide unit: one bit per cycle on operand magnitudes.
// Latency: hi/lo/done update N+1 edges after the start edge; MTHI/MTLO write at the start edge.
// Backpressure: start is ignored while busy; no queuing of requests.
module iter_multdiv
  import multdiv_pkg::*;
#(
  parameter int N = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   F,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         dz,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic [N-1:0] y
);

  localparam int CW = $clog2(N);

  state_e          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [2*N:0]    acc;
  logic [N-1:0]    ma_q, mb_q, a_q;
  logic            div_q, sgn_q, na_q, nb_q, bz_q;

  logic            last;
  logic            sgn_in;
  logic [N-1:0]    ma_in, mb_in;
  logic [N:0]      mul_sum;
  logic [N:0]      rem_nx;
  logic            qbit;
  logic [2*N:0]    acc_nx;
  logic [2*N-1:0]  prod;
  logic [N-1:0]    quo, rem;
  logic [N-1:0]    fix_hi, fix_lo;

  assign last   = (cnt == CW'(N - 1));
  assign busy   = (state != S_IDLE);
  assign y      = (F == OP_MFHI) ? hi : lo;

  assign sgn_in = is_signed_op(F);
  assign ma_in  = (sgn_in && a[N-1]) ? (~a + 1'b1) : a;
  assign mb_in  = (sgn_in && b[N-1]) ? (~b + 1'b1) : b;

  div_step #(.N(N)) u_div_step (
    .rem_in  (acc[2*N:N]),
    .bit_in  (acc[N-1]),
    .divisor (mb_q),
    .rem_out (rem_nx),
    .qbit    (qbit)
  );

  // Multiply keeps the multiplier in acc[N-1:0] and shifts the partial product down into it.
  assign mul_sum = acc[2*N:N] + (acc[0] ? {1'b0, ma_q} : {(N+1){1'b0}});
  assign acc_nx  = div_q ? {rem_nx, acc[N-2:0], qbit} : {1'b0, mul_sum, acc[N-1:1]};

  always_comb begin
    prod   = acc[2*N-1:0];
    quo    = acc[N-1:0];
    rem    = acc[2*N-1:N];
    fix_hi = '0;
    fix_lo = '0;
    if (sgn_q && (na_q ^ nb_q)) begin
      prod = ~prod + 1'b1;
      quo  = ~quo + 1'b1;
    end
    if (sgn_q && na_q) rem = ~rem + 1'b1;
    if (!div_q) begin
      {fix_hi, fix_lo} = prod;
    end else if (bz_q) begin
      fix_hi = a_q;
      fix_lo = '1;
    end else begin
      fix_hi = rem;
      fix_lo = quo;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start && is_md_op(F)) state_nx = S_CALC;
      S_CALC:  if (last) state_nx = S_FIX;
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi    <= '0;
      lo    <= '0;
      dz    <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      ma_q  <= '0;
      mb_q  <= '0;
      a_q   <= '0;
      div_q <= 1'b0;
      sgn_q <= 1'b0;
      na_q  <= 1'b0;
      nb_q  <= 1'b0;
      bz_q  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && is_md_op(F)) begin
            cnt   <= '0;
            ma_q  <= ma_in;
            mb_q  <= mb_in;
            a_q   <= a;
            div_q <= F[1];
            sgn_q <= sgn_in;
            na_q  <= a[N-1];
            nb_q  <= b[N-1];
            bz_q  <= (b == '0);
            acc   <= F[1] ? {{(N+1){1'b0}}, ma_in} : {{(N+1){1'b0}}, mb_in};
          end else if (start && F == OP_MTHI) begin
            hi <= a;
          end else if (start && F == OP_MTLO) begin
            lo <= a;
          end
        end
        S_CALC: begin
          cnt <= cnt + 1'b1;
          acc <= acc_nx;
        end
        S_FIX: begin
          hi   <= fix_hi;
          lo   <= fix_lo;
          dz   <= div_q && bz_q;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_multdiv.sv
// Directed + randomized bench for iter_multdiv against an arithmetic reference model.
module tb_iter_multdiv;

  localparam int N = 18;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    F = 4'h0;
  logic [N-1:0]  a = '0;
  logic [N-1:0]  b = '0;
  logic          busy, done, dz;
  logic [N-1:0]  hi, lo, y;

  int tests = 0;
  int fails = 0;

  iter_multdiv #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .F(F), .a(a), .b(b),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo), .y(y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plain integer arithmetic: SV division truncates toward zero and % follows the dividend.
  function automatic void ref_model(input logic [3:0] f, input logic [N-1:0] ra, input logic [N-1:0] rb,
                                    output logic [N-1:0] eh, output logic [N-1:0] el, output logic edz);
    longint sa, sb, ua, ub, q, r;
    logic [63:0] p;
    sa = {{(64-N){ra[N-1]}}, ra};
    sb = {{(64-N){rb[N-1]}}, rb};
    ua = {{(64-N){1'b0}}, ra};
    ub = {{(64-N){1'b0}}, rb};
    edz = 1'b0;
    eh = '0;
    el = '0;
    if (f == 4'h8 || f == 4'h9) begin
      p = (f == 4'h8) ? sa * sb : ua * ub;
      eh = p[2*N-1:N];
      el = p[N-1:0];
    end else if (rb == '0) begin
      edz = 1'b1;
      eh = ra;
      el = '1;
    end else begin
      q = (f == 4'hA) ? sa / sb : ua / ub;
      r = (f == 4'hA) ? sa % sb : ua % ub;
      eh = r[N-1:0];
      el = q[N-1:0];
    end
  endfunction

  task automatic launch(input logic [3:0] f, input logic [N-1:0] va, input logic [N-1:0] vb);
    start = 1'b1; F = f; a = va; b = vb;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns the number of edges from the start edge to the done pulse, or -1 on timeout.
  task automatic wait_done(output int lat, output int busy_drop);
    lat = -1;
    busy_drop = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
      if (!busy) busy_drop++;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] f, input logic [N-1:0] va, input logic [N-1:0] vb);
    logic [N-1:0] eh, el;
    logic edz;
    int lat, bd;
    ref_model(f, va, vb, eh, el, edz);
    launch(f, va, vb);
    wait_done(lat, bd);
    check({tag, " latency"}, 36'(lat), 36'(N + 1));
    check({tag, " busy held"}, 36'(bd), 36'd0);
    check({tag, " hi/lo"}, {hi, lo}, {eh, el});
    check({tag, " dz"}, 36'(dz), 36'(edz));
    @(posedge clk); #1;
    check({tag, " done 1-cycle"}, 36'(done), 36'd0);
  endtask

  initial begin
    logic [N-1:0] ra, rb, eh, el, lo_before;
    logic [3:0]   rf;
    logic         edz;
    int           lat, bd, pulses;

    // Reset: start is asserted at the reset edge and must be ignored.
    start = 1'b1; F = 4'h8; a = 18'h3; b = 18'h3;
    @(posedge clk); #1;
    start = 1'b0;
    rst_n = 1'b1;
    check("reset busy", 36'(busy), 36'd0);
    check("reset done", 36'(done), 36'd0);
    check("reset dz", 36'(dz), 36'd0);
    check("reset hi/lo", {hi, lo}, 36'd0);

    run_op("multu max", 4'h9, 18'h3FFFF, 18'h3FFFF);
    check("multu max hi", 36'(hi), 36'h3FFFE);
    check("multu max lo", 36'(lo), 36'h00001);
    run_op("mult -3*5", 4'h8, 18'h3FFFD, 18'h00005);
    check("mult -3*5 hilo", {hi, lo}, {18'h3FFFF, 18'h3FFF1});
    run_op("div -7/2", 4'hA, 18'h3FFF9, 18'h00002);
    check("div -7/2 hilo", {hi, lo}, {18'h3FFFF, 18'h3FFFD});
    run_op("divu /0", 4'hB, 18'h00064, 18'h00000);
    check("divu /0 hilo", {hi, lo}, {18'h00064, 18'h3FFFF});
    check("divu /0 dz", 36'(dz), 36'd1);
    run_op("div ovf", 4'hA, 18'h20000, 18'h3FFFF);
    check("div ovf hilo", {hi, lo}, {18'h00000, 18'h20000});
    check("div ovf dz", 36'(dz), 36'd0);

    // MTLO while busy is dropped; lo keeps its old value until the result lands.
    lo_before = lo;
    ref_model(4'h9, 18'h00007, 18'h00009, eh, el, edz);
    launch(4'h9, 18'h00007, 18'h00009);
    repeat (3) @(posedge clk);
    #1;
    launch(4'h3, 18'h00ABC, 18'h0);
    check("mtlo busy ignored", 36'(lo), 36'(lo_before));
    wait_done(lat, bd);
    check("mtlo busy latency", 36'(lat), 36'(N + 1 - 4));
    check("mtlo busy result", 36'(lo), 36'(el));
    @(posedge clk); #1;
    launch(4'h1, 18'h00123, 18'h0);
    check("mthi hi", 36'(hi), 36'h00123);
    check("mthi no done", 36'(done), 36'd0);
    check("mthi no busy", 36'(busy), 36'd0);
    F = 4'h0; #1;
    check("y mfhi", 36'(y), 36'h00123);
    F = 4'h2; #1;
    check("y mflo", 36'(y), 36'(el));

    // Reset mid-CALC, then confirm no stray done pulse.
    launch(4'h8, 18'h12345, 18'h01234);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst busy", 36'(busy), 36'd0);
    check("midrst hi/lo", {hi, lo}, 36'd0);
    check("midrst done", 36'(done), 36'd0);
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("midrst no done", 36'(pulses), 36'd0);
    run_op("multu 2x3", 4'h9, 18'h00002, 18'h00003);
    check("multu 2x3 lo", 36'(lo), 36'h00006);

    // Randomized operations, with corner operand values mixed in.
    for (int i = 0; i < 40; i++) begin
      rf = 4'h8 + 4'($urandom_range(0, 3));
      ra = 18'($urandom);
      rb = 18'($urandom);
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: ra = 18'h20000;
        2: rb = 18'h3FFFF;
        3: rb = 18'($urandom_range(1, 15));
        default: ;
      endcase
      run_op($sformatf("rand%0d f%0h", i, rf), rf, ra, rb);
      if ($urandom_range(0, 3) == 0) begin
        ra = 18'($urandom);
        launch(4'h3, ra, 18'h0);
        check($sformatf("rand%0d mtlo", i), 36'(lo), 36'(ra));
      end
    end

    // An undefined opcode must leave everything untouched.
    eh = hi; el = lo;
    launch(4'h5, 18'h11111, 18'h22222);
    check("bad opcode busy", 36'(busy), 36'd0);
    check("bad opcode hilo", {hi, lo}, {eh, el});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
